sevseg_scan_mux: RTL and testbench
==================================

// Module: sevseg_scan_mux
// PURPOSE
//  Parametrised time-multiplexed hex display driver for N common-enable 7-segment digits.
//  Successor of the fixed 4-digit scanner; adds a refresh prescaler, anti-ghost dead time,
//  a tear-free frame-synchronised value load, per-digit decimal points and leading-zero blanking.
//  Sits between the datapath result registers and the board's segment/anode pins.
// PARAMETERS
//  N_DIGITS  4      number of digits scanned, legal 2..8
//  CLK_DIV   50000  clk cycles per digit slot, legal >= 2
//  DEAD_CYC  2      cycles at the start of each slot with all digits off, legal 0..CLK_DIV-1
// PORTS
//  clk         in   1           system clock, all logic on rising edge
//  rst         in   1           synchronous reset, active-high
//  value_in    in   4*N_DIGITS  hex nibbles, digit i = value_in[4i+3:4i], digit 0 is least significant
//  dp_in       in   N_DIGITS    decimal point request per digit, 1 = lit
//  load        in   1           1-cycle strobe, captures value_in/dp_in
//  lz_blank    in   1           1 = blank leading zero digits
//  seg_n       out  7           segments {a,b,c,d,e,f,g}, active-low
//  dp_n        out  1           decimal point, active-low
//  dig_en      out  N_DIGITS    one-hot digit enable, active-high
//  frame_tick  out  1           1-cycle pulse when the last slot of a frame ends
// BEHAVIOUR
//  Reset: prescaler=0, idx=0, pending/display regs=0, pend_flag=0, seg_n=7'h7F, dp_n=1,
//   dig_en=0, frame_tick=0. Reset takes effect on any cycle, including mid-frame.
//  Prescaler pc counts 0..CLK_DIV-1 and wraps. At pc==CLK_DIV-1, idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
//  Frame boundary fb = (pc==CLK_DIV-1 && idx==N_DIGITS-1). frame_tick is registered, high the cycle after fb.
//  Load: load=1 writes value_in/dp_in to pending regs and sets pend_flag.
//   On fb with pend_flag=1 or load=1: display <= load ? inputs : pending, pend_flag <= 0.
//   load on the fb cycle goes straight to display. Repeated loads within a frame: last one wins.
//   A displayed value never changes mid-frame.
//  Outputs are registered: one-cycle latency from (pc,idx) to pins.
//   dig_en = one-hot(idx) when pc >= DEAD_CYC, else all 0. In dead time, seg_n=7'h7F and dp_n=1.
//  Decode, active-low {a..g}: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//   6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010
//   E=0110000 F=0111000.
//  dp_n = ~display_dp[idx].
//  LZ blanking: with lz_blank=1, digit i (i>0) is blanked when display nibbles i..N_DIGITS-1
//   are all 0. Blanked means seg_n=7'h7F. dig_en and dp_n are still driven normally.
//   Digit 0 is never blanked, so a value of 0 shows "0". lz_blank is sampled every cycle, not latched.
// CONFIGURATION
//  SEVSEG_BLINK_EN defined:
//   - Adds parameter BLINK_FRAMES (default 64, >=1) and input blink_mask [N_DIGITS-1:0].
//   - A frame counter toggles blink_ph every BLINK_FRAMES frame_ticks. blink_ph resets to 0 (on).
//   - While blink_ph=1, digits with blink_mask[i]=1 output seg_n=7'h7F and dp_n=1.
//   - blink_mask is sampled live.
//  SEVSEG_BLINK_EN undefined: no port, parameter or counter; all digits always lit.
// TESTING (N_DIGITS=4, CLK_DIV=4, DEAD_CYC=1)
//  1. rst for 3 cycles mid-scan -> seg_n=7F, dig_en=0, frame_tick=0 one cycle after release;
//     first enable is dig_en=0001.
//  2. load 16'h1B2D, then free-run -> per frame dig_en 0001/0010/0100/1000, each high for 3 of 4
//     cycles; seg_n = 1000010 / 0010010 / 1100000 / 1001111; frame_tick period is 16 cycles.
//  3. load 16'h00A0 mid-frame -> old value held until frame_tick; then 0A0 shown;
//     load coincident with fb -> new value displayed in the next slot.
//  4. lz_blank=1 with 16'h0050 -> digits 3,2 seg_n=7F; digit1=0100100, digit0=0000001;
//     value 0 -> only digit 0 shows "0".
//  5. dp_in=4'b0100 -> dp_n=0 only while dig_en=0100, and dp_n=1 in dead time.
//  6. SEVSEG_BLINK_EN, BLINK_FRAMES=2, blink_mask=0001 -> digit 0 dark for frames 2-3,
//     lit for 4-5; other digits never dark.

Source files
------------

// File: rtl/sevseg_scan_mux.sv
// sevseg_scan_mux
//   Time-multiplexed hex display driver for N_DIGITS common-enable 7-segment digits.
//   A prescaler divides clk into digit slots; each slot starts with DEAD_CYC cycles
//   with every digit off to suppress ghosting. New values are captured into pending
//   registers and only transferred to the display registers at the frame boundary,
//   so a frame never shows a mix of old and new digits.
//
// Parameters
//   N_DIGITS      digits scanned (2..8)
//   CLK_DIV       clk cycles per digit slot (>= 2)
//   DEAD_CYC      all-off cycles at the start of each slot (0..CLK_DIV-1)
//   BLINK_FRAMES  frames per blink half-period (only with SEVSEG_BLINK_EN)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   value_in    hex nibbles, digit i = value_in[4i+3:4i], digit 0 least significant
//   dp_in       decimal point request per digit, 1 = lit
//   load        1-cycle strobe capturing value_in/dp_in
//   lz_blank    1 = blank leading zero digits (sampled every cycle)
//   blink_mask  digits that go dark in the off blink phase (only with SEVSEG_BLINK_EN)
//   seg_n       segments {a,b,c,d,e,f,g}, active-low
//   dp_n        decimal point, active-low
//   dig_en      one-hot digit enable, active-high
//   frame_tick  1-cycle pulse after the last slot of a frame
//
// Build option
//   SEVSEG_BLINK_EN  adds BLINK_FRAMES, blink_mask and the frame-based blink phase.

module sevseg_scan_mux #(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned DEAD_CYC     = 2
`ifdef SEVSEG_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    input  logic                  lz_blank,
`ifdef SEVSEG_BLINK_EN
    input  logic [N_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   dig_en,
    output logic                  frame_tick
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam int unsigned IW = $clog2(N_DIGITS);

    localparam logic [PW-1:0] LastPc  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] DeadPc  = PW'(DEAD_CYC);
    localparam logic [IW-1:0] LastIdx = IW'(N_DIGITS - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    logic [PW-1:0]              pc_q, pc_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [N_DIGITS-1:0][3:0]   pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0]        pend_dp_q, pend_dp_d;
    logic                       pend_flag_q, pend_flag_d;
    logic [N_DIGITS-1:0][3:0]   disp_val_q, disp_val_d;
    logic [N_DIGITS-1:0]        disp_dp_q, disp_dp_d;
    logic [6:0]                 seg_q, seg_d;
    logic                       dp_q, dp_d;
    logic [N_DIGITS-1:0]        dig_en_q, dig_en_d;
    logic                       frame_tick_q;
    logic                       fb;
    logic                       blank;

`ifdef SEVSEG_BLINK_EN
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] LastBlink = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
`endif

    // Scan position and display-register update.
    always_comb begin
        fb          = (pc_q == LastPc) && (idx_q == LastIdx);
        pc_d        = (pc_q == LastPc) ? '0 : pc_q + 1'b1;
        idx_d       = idx_q;
        if (pc_q == LastPc) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end

        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        if (load) begin
            pend_val_d  = value_in;
            pend_dp_d   = dp_in;
            pend_flag_d = 1'b1;
        end
        // A load on the boundary cycle bypasses pending and goes straight to display.
        if (fb && (pend_flag_q || load)) begin
            disp_val_d  = load ? value_in : pend_val_q;
            disp_dp_d   = load ? dp_in : pend_dp_q;
            pend_flag_d = 1'b0;
        end

`ifdef SEVSEG_BLINK_EN
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (fb) begin
            if (blink_cnt_q == LastBlink) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
`endif
    end

    // Digit idx is a leading zero when it and every more-significant nibble are 0.
    always_comb begin
        blank = lz_blank && (idx_q != '0);
        for (int unsigned i = 1; i < N_DIGITS; i++) begin
            if ((IW'(i) >= idx_q) && (disp_val_q[i] != 4'h0)) begin
                blank = 1'b0;
            end
        end
    end

    // Pin values for the current (pc, idx); registered below.
    always_comb begin
        dig_en_d = '0;
        seg_d    = 7'h7F;
        dp_d     = 1'b1;
        if (pc_q >= DeadPc) begin
            dig_en_d[idx_q] = 1'b1;
            seg_d           = blank ? 7'h7F : hex_to_seg(disp_val_q[idx_q]);
            dp_d            = ~disp_dp_q[idx_q];
`ifdef SEVSEG_BLINK_EN
            if (blink_ph_q && blink_mask[idx_q]) begin
                seg_d = 7'h7F;
                dp_d  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            dig_en_q     <= '0;
            frame_tick_q <= 1'b0;
`ifdef SEVSEG_BLINK_EN
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
`endif
        end else begin
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_en_q     <= dig_en_d;
            frame_tick_q <= fb;
`ifdef SEVSEG_BLINK_EN
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
`endif
        end
    end

    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign dig_en     = dig_en_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevseg_scan_mux.sv
// tb_sevseg_scan_mux
//   Directed bench for sevseg_scan_mux with N_DIGITS=4, CLK_DIV=4, DEAD_CYC=1
//   (BLINK_FRAMES=2 when SEVSEG_BLINK_EN is defined). Each frame is 16 cycles:
//   4 slots of 4 cycles, the first cycle of each slot dark.

module tb_sevseg_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_blank;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  dig_en;
    logic        frame_tick;
`ifdef SEVSEG_BLINK_EN
    logic [3:0]  blink_mask;
`endif

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_segs [4];
    logic [3:0] exp_dig;
    logic [6:0] exp_seg;
    logic       exp_dp;

    sevseg_scan_mux #(
        .N_DIGITS(4),
        .CLK_DIV(4),
        .DEAD_CYC(1)
`ifdef SEVSEG_BLINK_EN
        ,
        .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .value_in(value_in),
        .dp_in(dp_in),
        .load(load),
        .lz_blank(lz_blank),
`ifdef SEVSEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg_n(seg_n),
        .dp_n(dp_n),
        .dig_en(dig_en),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    // Steps until frame_tick is seen; outputs then reflect the last slot of a frame.
    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; value_in = '0; dp_in = '0; lz_blank = 1'b0;
        step();
        step();
        rst = 1'b0;
        do_load(16'h1111, 4'b1111);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        checks += 3;
        if (dig_en !== 4'b0000)
            begin errors++; $display("FAIL rst_hold_dig: got %b want 0000", dig_en); end
        if (seg_n !== 7'h7F)
            begin errors++; $display("FAIL rst_hold_seg: got %h want 7f", seg_n); end
        if (frame_tick !== 1'b0)
            begin errors++; $display("FAIL rst_hold_ft: got %b want 0", frame_tick); end
        step();
        step();
        rst = 1'b0;
        step();
        checks += 4;
        if (seg_n !== 7'h7F)
            begin errors++; $display("FAIL rst_rel_seg: got %h want 7f", seg_n); end
        if (dig_en !== 4'b0000)
            begin errors++; $display("FAIL rst_rel_dig: got %b want 0000", dig_en); end
        if (frame_tick !== 1'b0)
            begin errors++; $display("FAIL rst_rel_ft: got %b want 0", frame_tick); end
        if (dp_n !== 1'b1)
            begin errors++; $display("FAIL rst_rel_dp: got %b want 1", dp_n); end
        step();
        checks += 3;
        if (dig_en !== 4'b0001)
            begin errors++; $display("FAIL rst_first_dig: got %b want 0001", dig_en); end
        if (seg_n !== 7'b0000001)
            begin errors++; $display("FAIL rst_first_seg: got %b want 0000001", seg_n); end
        if (dp_n !== 1'b1)
            begin errors++; $display("FAIL rst_first_dp: got %b want 1", dp_n); end
    endtask

    task automatic test_decode();
        bit ok;
        do_load(16'h1B2D, 4'b0000);
        wait_frame(ok);
        checks++;
        if (ok !== 1'b1)
            begin errors++; $display("FAIL decode_sync: frame_tick got 0 want 1"); end
        exp_segs = '{7'b1000010, 7'b0010010, 7'b1100000, 7'b1001111};
        for (int j = 1; j <= 16; j++) begin
            step();
            exp_dig = ((j - 1) % 4 >= 1) ? 4'(1 << ((j - 1) / 4)) : 4'b0000;
            exp_seg = ((j - 1) % 4 >= 1) ? exp_segs[(j - 1) / 4] : 7'h7F;
            checks += 4;
            if (dig_en !== exp_dig)
                begin errors++; $display("FAIL decode_dig c%0d: got %b want %b", j, dig_en, exp_dig); end
            if (seg_n !== exp_seg)
                begin errors++; $display("FAIL decode_seg c%0d: got %b want %b", j, seg_n, exp_seg); end
            if (dp_n !== 1'b1)
                begin errors++; $display("FAIL decode_dp c%0d: got %b want 1", j, dp_n); end
            if (frame_tick !== (j == 16))
                begin errors++; $display("FAIL decode_ft c%0d: got %b want %b", j, frame_tick, j == 16); end
        end
    endtask

    task automatic test_frame_sync();
        bit ok;
        wait_frame(ok);
        checks++;
        if (ok !== 1'b1)
            begin errors++; $display("FAIL sync_sync: frame_tick got 0 want 1"); end
        // Mid-frame load must not disturb the frame being shown.
        exp_segs = '{7'b1000010, 7'b0010010, 7'b1100000, 7'b1001111};
        for (int j = 1; j <= 16; j++) begin
            if (j == 6) begin value_in = 16'h00A0; dp_in = 4'b0000; load = 1'b1; end
            step();
            load = 1'b0;
            exp_dig = ((j - 1) % 4 >= 1) ? 4'(1 << ((j - 1) / 4)) : 4'b0000;
            exp_seg = ((j - 1) % 4 >= 1) ? exp_segs[(j - 1) / 4] : 7'h7F;
            checks += 2;
            if (dig_en !== exp_dig)
                begin errors++; $display("FAIL hold_dig c%0d: got %b want %b", j, dig_en, exp_dig); end
            if (seg_n !== exp_seg)
                begin errors++; $display("FAIL hold_seg c%0d: got %b want %b", j, seg_n, exp_seg); end
        end
        // 00A0 now shown; a load on the boundary cycle of this frame lands next frame.
        exp_segs = '{7'b0000001, 7'b0001000, 7'b0000001, 7'b0000001};
        for (int j = 1; j <= 16; j++) begin
            if (j == 16) begin value_in = 16'h4321; load = 1'b1; end
            step();
            load = 1'b0;
            exp_seg = ((j - 1) % 4 >= 1) ? exp_segs[(j - 1) / 4] : 7'h7F;
            checks += 2;
            if (seg_n !== exp_seg)
                begin errors++; $display("FAIL newval_seg c%0d: got %b want %b", j, seg_n, exp_seg); end
            if (frame_tick !== (j == 16))
                begin errors++; $display("FAIL newval_ft c%0d: got %b want %b", j, frame_tick, j == 16); end
        end
        exp_segs = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
        for (int j = 1; j <= 16; j++) begin
            step();
            exp_seg = ((j - 1) % 4 >= 1) ? exp_segs[(j - 1) / 4] : 7'h7F;
            checks++;
            if (seg_n !== exp_seg)
                begin errors++; $display("FAIL fbload_seg c%0d: got %b want %b", j, seg_n, exp_seg); end
        end
    endtask

    task automatic test_lz_blank();
        bit ok;
        lz_blank = 1'b1;
        // Back-to-back loads: the later one must win.
        do_load(16'h1234, 4'b0000);
        do_load(16'h0050, 4'b0000);
        wait_frame(ok);
        checks++;
        if (ok !== 1'b1)
            begin errors++; $display("FAIL lz_sync: frame_tick got 0 want 1"); end
        exp_segs = '{7'b0000001, 7'b0100100, 7'h7F, 7'h7F};
        for (int j = 1; j <= 16; j++) begin
            step();
            exp_dig = ((j - 1) % 4 >= 1) ? 4'(1 << ((j - 1) / 4)) : 4'b0000;
            exp_seg = ((j - 1) % 4 >= 1) ? exp_segs[(j - 1) / 4] : 7'h7F;
            checks += 2;
            if (dig_en !== exp_dig)
                begin errors++; $display("FAIL lz50_dig c%0d: got %b want %b", j, dig_en, exp_dig); end
            if (seg_n !== exp_seg)
                begin errors++; $display("FAIL lz50_seg c%0d: got %b want %b", j, seg_n, exp_seg); end
        end
        do_load(16'h0000, 4'b0000);
        wait_frame(ok);
        checks++;
        if (ok !== 1'b1)
            begin errors++; $display("FAIL lz0_sync: frame_tick got 0 want 1"); end
        exp_segs = '{7'b0000001, 7'h7F, 7'h7F, 7'h7F};
        for (int j = 1; j <= 16; j++) begin
            step();
            exp_seg = ((j - 1) % 4 >= 1) ? exp_segs[(j - 1) / 4] : 7'h7F;
            checks++;
            if (seg_n !== exp_seg)
                begin errors++; $display("FAIL lz0_seg c%0d: got %b want %b", j, seg_n, exp_seg); end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_dp();
        bit ok;
        do_load(16'h1B2D, 4'b0100);
        wait_frame(ok);
        checks++;
        if (ok !== 1'b1)
            begin errors++; $display("FAIL dp_sync: frame_tick got 0 want 1"); end
        exp_segs = '{7'b1000010, 7'b0010010, 7'b1100000, 7'b1001111};
        for (int j = 1; j <= 16; j++) begin
            step();
            exp_seg = ((j - 1) % 4 >= 1) ? exp_segs[(j - 1) / 4] : 7'h7F;
            exp_dp  = !(((j - 1) % 4 >= 1) && ((j - 1) / 4 == 2));
            checks += 2;
            if (dp_n !== exp_dp)
                begin errors++; $display("FAIL dp_dp c%0d: got %b want %b", j, dp_n, exp_dp); end
            if (seg_n !== exp_seg)
                begin errors++; $display("FAIL dp_seg c%0d: got %b want %b", j, seg_n, exp_seg); end
        end
    endtask

`ifdef SEVSEG_BLINK_EN
    task automatic test_blink();
        int c;
        bit dark;
        blink_mask = 4'b0000;
        lz_blank   = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        blink_mask = 4'b0001;
        // Display is all zeros after reset; frames 2-3 darken digit 0.
        for (int k = 1; k <= 96; k++) begin
            step();
            c       = k - 1;
            dark    = ((c / 16 == 2) || (c / 16 == 3)) && ((c % 16) / 4 == 0);
            exp_dig = (c % 4 >= 1) ? 4'(1 << ((c % 16) / 4)) : 4'b0000;
            exp_seg = (c % 4 >= 1 && !dark) ? 7'b0000001 : 7'h7F;
            checks += 3;
            if (dig_en !== exp_dig)
                begin errors++; $display("FAIL blink_dig c%0d: got %b want %b", c, dig_en, exp_dig); end
            if (seg_n !== exp_seg)
                begin errors++; $display("FAIL blink_seg c%0d: got %b want %b", c, seg_n, exp_seg); end
            if (dp_n !== 1'b1)
                begin errors++; $display("FAIL blink_dp c%0d: got %b want 1", c, dp_n); end
        end
    endtask
`endif

    initial begin
`ifdef SEVSEG_BLINK_EN
        blink_mask = 4'b0000;
`endif
        test_reset();
        test_decode();
        test_frame_sync();
        test_lz_blank();
        test_dp();
`ifdef SEVSEG_BLINK_EN
        test_blink();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
